// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - multiply/divide unit op encodings, states and decode helpers
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 64-bit mult/div result generator with div-by-zero flag
module md_arith
  import md_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'b0, a} * {32'b0, b};
    sgn      = (op == MD_DIV);
    abs_a    = (sgn && a[31]) ? -a : a;
    abs_b    = (sgn && b[31]) ? -b : b;
    div_zero = md_is_div(op) && (b == 32'd0);
    dvs      = div_zero ? 32'd1 : abs_b;
    quo      = abs_a / dvs;
    rem      = abs_a % dvs;
    if (sgn && (a[31] ^ b[31])) quo = -quo;
    if (sgn && a[31]) rem = -rem;
    case (op)
      MD_MULT:          result = prod_s;
      MD_MULTU:         result = prod_u;
      MD_DIV, MD_DIVU:  result = {rem, quo};
      default:          result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit owning HI/LO with fixed multi-cycle latency
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_rd_sel,
  output logic [31:0] md_rdata,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  md_state_t   state;
  md_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;
  logic [63:0] arith_result;
  logic        arith_div_zero;

  md_arith u_arith (
    .op       (md_op),
    .a        (md_a),
    .b        (md_b),
    .result   (arith_result),
    .div_zero (arith_div_zero)
  );

  assign md_start = md_is_start(md_op);
  assign md_busy  = (state == MD_BUSY);
  assign md_stall = md_start | md_busy;
  assign md_rdata = md_rd_sel ? hi : lo;

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (md_start) state_nxt = MD_BUSY;
      MD_BUSY: if (cnt == CW'(1)) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Ops arriving while BUSY are dropped; the stall unit keeps them out of E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            res_hi <= arith_result[63:32];
            res_lo <= arith_result[31:0];
            res_wr <= !arith_div_zero;
            cnt    <= md_is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end else if (md_op == MD_MTHI) begin
            hi <= md_a;
          end else if (md_op == MD_MTLO) begin
            lo <= md_a;
          end
        end
        MD_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1) && res_wr) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_rd_sel;
  logic [31:0] md_rdata;
  logic        md_start;
  logic        md_busy;
  logic        md_stall;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        keep;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .md_rd_sel (md_rd_sel),
    .md_rdata  (md_rdata),
    .md_start  (md_start),
    .md_busy   (md_busy),
    .md_stall  (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset && md_busy && md_op != MD_NONE) begin
      n_fail++;
      $display("FAIL op_while_busy: op %0d driven while busy, required none", md_op);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    md_rd_sel = 1'b1;
    #1 h = md_rdata;
    md_rd_sel = 1'b0;
    #1 l = md_rdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] oh, ol, h, l;
    int   n;
    exp_t e;
    @(negedge clk);
    read_hilo(oh, ol);
    md_op = v.op;
    md_a  = v.a;
    md_b  = v.b;
    #1;
    check($sformatf("v%0d_stall_on_start", idx), 32'(md_stall), 32'd1);
    check($sformatf("v%0d_busy_on_start", idx), 32'(md_busy), 32'd0);
    e.hi     = v.keep ? oh : v.hi;
    e.lo     = v.keep ? ol : v.lo;
    e.cycles = (v.op == MD_DIV || v.op == MD_DIVU) ? DC : MC;
    sb.push_back(e);
    @(posedge clk);
    #1;
    md_op = MD_NONE;
    md_a  = $urandom;
    md_b  = $urandom;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (!md_busy) break;
      read_hilo(h, l);
      check($sformatf("v%0d_hi_hold_c%0d", idx, n + 1), h, oh);
      check($sformatf("v%0d_lo_hold_c%0d", idx, n + 1), l, ol);
    end
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL v%0d_scoreboard: queue empty, required one entry", idx);
    end else begin
      e = sb.pop_front();
      read_hilo(h, l);
      check($sformatf("v%0d_busy_cycles", idx), 32'(n), 32'(e.cycles));
      check($sformatf("v%0d_hi", idx), h, e.hi);
      check($sformatf("v%0d_lo", idx), l, e.lo);
    end
  endtask

  initial begin
    logic [31:0] h, l;
    n_vec     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    md_op     = MD_NONE;
    md_a      = 32'd0;
    md_b      = 32'd0;
    md_rd_sel = 1'b0;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[5] = '{MD_DIV,   32'd5,        32'd0,        32'd0,        32'd0,        1'b1};
    vecs[6] = '{MD_DIVU,  32'd5,        32'd0,        32'd0,        32'd0,        1'b1};
    vecs[7] = '{MD_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[8] = '{MD_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

    repeat (2) @(negedge clk);
    read_hilo(h, l);
    check("reset_busy", 32'(md_busy), 32'd0);
    check("reset_stall", 32'(md_stall), 32'd0);
    check("reset_hi", h, 32'd0);
    check("reset_lo", l, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // mthi/mtlo are single-cycle and never raise busy or stall
    @(negedge clk);
    md_op = MD_MTHI;
    md_a  = 32'h1234;
    #1 check("mthi_stall", 32'(md_stall), 32'd0);
    @(posedge clk);
    #1;
    md_op = MD_MTLO;
    md_a  = 32'h5678;
    @(negedge clk);
    check("mtlo_busy", 32'(md_busy), 32'd0);
    @(posedge clk);
    #1 md_op = MD_NONE;
    @(negedge clk);
    read_hilo(h, l);
    check("mt_busy", 32'(md_busy), 32'd0);
    check("mthi_value", h, 32'h1234);
    check("mtlo_value", l, 32'h5678);

    // undefined op code leaves everything alone
    md_op = 4'hF;
    md_a  = 32'hDEAD;
    #1 check("undef_stall", 32'(md_stall), 32'd0);
    @(posedge clk);
    #1 md_op = MD_NONE;
    @(negedge clk);
    read_hilo(h, l);
    check("undef_busy", 32'(md_busy), 32'd0);
    check("undef_hi", h, 32'h1234);
    check("undef_lo", l, 32'h5678);

    // reset on busy cycle 2 aborts the mult
    @(negedge clk);
    md_op = MD_MULT;
    md_a  = 32'd3;
    md_b  = 32'd4;
    @(posedge clk);
    #1 md_op = MD_NONE;
    @(negedge clk);
    check("abort_busy_c1", 32'(md_busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    read_hilo(h, l);
    check("abort_busy", 32'(md_busy), 32'd0);
    check("abort_hi", h, 32'd0);
    check("abort_lo", l, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    read_hilo(h, l);
    check("post_abort_busy", 32'(md_busy), 32'd0);
    check("post_abort_hi", h, 32'd0);
    check("post_abort_lo", l, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
